// File: rtl/uart_if.sv
// Host-side register interface of the UART: TX load/busy, RX FIFO head/pop, sticky errors, interrupt.
interface uart_if;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_re;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;
  logic       intr;

  modport master (
    output tx_data, tx_we, rx_re, err_clr,
    input  tx_busy, rx_data, rx_ready, overrun, frame_err, intr
  );

  modport slave (
    input  tx_data, tx_we, rx_re, err_clr,
    output tx_busy, rx_data, rx_ready, overrun, frame_err, intr
  );
endinterface

// File: rtl/uart.sv
// 8N1 UART with a show-ahead RX FIFO; TX starts the cycle after tx_we, RX bytes appear the cycle after the stop sample.
// No flow control: tx_we while busy is ignored, RX bytes arriving into a full FIFO are dropped and flagged.
module uart #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   rx,
  output logic   tx,
  uart_if.slave  bus
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick     = (tx_cnt == FULL_CNT);
  assign bus.tx_busy = (tx_state != T_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= T_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx           = 1'b1;
    case (tx_state)
      T_IDLE:  if (bus.tx_we) tx_state_nxt = T_START;
      T_START: begin
        tx = 1'b0;
        if (tx_tick) tx_state_nxt = T_DATA;
      end
      T_DATA: begin
        tx = tx_sh[0];
        if (tx_tick && tx_bit == 3'd7) tx_state_nxt = T_STOP;
      end
      T_STOP:  if (tx_tick) tx_state_nxt = T_IDLE;
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_state == T_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (bus.tx_we) tx_sh <= bus.tx_data;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      if (tx_state == T_DATA && tx_tick) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  rx_state_t     rx_state, rx_state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_sample, rx_push, rx_ferr;

  // Synchronizers idle high so reset release on an idle line never looks like a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= R_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_sample    = 1'b0;
    rx_push      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      R_IDLE: if (rx_prev && !rx_sync) rx_state_nxt = R_START;
      R_START: if (rx_cnt == HALF_CNT) begin
        rx_sample    = 1'b1;
        rx_state_nxt = rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == FULL_CNT) begin
        rx_sample = 1'b1;
        if (rx_bit == 3'd7) rx_state_nxt = R_STOP;
      end
      R_STOP: if (rx_cnt == FULL_CNT) begin
        rx_sample    = 1'b1;
        rx_push      = rx_sync;
        rx_ferr      = !rx_sync;
        rx_state_nxt = rx_sync ? R_IDLE : R_BREAK;
      end
      // Bad stop bit: hold off until the line returns high so a long low is not read as a new start
      R_BREAK: if (rx_sync) rx_state_nxt = R_IDLE;
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_sample || rx_state == R_IDLE || rx_state == R_BREAK) rx_cnt <= '0;
      else                                                       rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == R_IDLE) rx_bit <= '0;
      if (rx_state == R_DATA && rx_sample) begin
        rx_sh  <= {rx_sync, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wp, rp, wp_nxt, rp_nxt;
  logic             empty, full, do_push, do_pop, drop, head_new;

  always_comb begin
    empty    = (wp == rp);
    full     = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    do_pop   = bus.rx_re && !empty;
    do_push  = rx_push && (!full || do_pop);
    drop     = rx_push && full && !do_pop;
    wp_nxt   = wp + {{FIFO_AW{1'b0}}, do_push};
    rp_nxt   = rp + {{FIFO_AW{1'b0}}, do_pop};
    // The new head is the byte being written this cycle when the write slot is where the read pointer lands
    head_new = do_push && (rp_nxt[FIFO_AW-1:0] == wp[FIFO_AW-1:0]);
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wp[FIFO_AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      bus.rx_data   <= '0;
      bus.rx_ready  <= 1'b0;
      bus.intr      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      wp           <= wp_nxt;
      rp           <= rp_nxt;
      bus.rx_ready <= (wp_nxt != rp_nxt);
      bus.intr     <= (wp_nxt != rp_nxt);
      if (wp_nxt != rp_nxt) bus.rx_data <= head_new ? rx_sh : mem[rp_nxt[FIFO_AW-1:0]];
      bus.overrun   <= drop    | (bus.overrun   & !bus.err_clr);
      bus.frame_err <= rx_ferr | (bus.frame_err & !bus.err_clr);
    end
  end
endmodule

// File: tb/tb_uart.sv
// Randomized and directed bench for uart: line-level frames checked against a queue model of the RX FIFO
// and a 10-bit frame model of the TX line.
`timescale 1ns/1ps
module tb_uart;
  localparam int DIV = 25_000_000 / 115200;
  // Clocks from the line going low (driven just after an edge) to the stop-bit sample:
  // 2 synchronizer stages + 1 edge-detect, DIV/2 to mid start bit, then 9 bit periods.
  localparam int RX_PUSH = 3 + DIV / 2 + 9 * DIV;

  logic clock = 1'b0, reset = 1'b1, rx_drv = 1'b1, loop = 1'b0;
  logic rx, tx;
  int   n_checks = 0, n_fail = 0;
  logic [7:0] q[$];

  uart_if bus ();
  assign rx = loop ? tx : rx_drv;

  uart dut (.clock(clock), .reset(reset), .rx(rx), .tx(tx), .bus(bus));

  always #20 clock = ~clock;

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      step(DIV);
    end
  endtask

  task automatic pop();
    bus.rx_re = 1'b1;
    step(1);
    bus.rx_re = 1'b0;
  endtask

  task automatic test_reset();
    bus.tx_data = 8'h00; bus.tx_we = 1'b0; bus.rx_re = 1'b0; bus.err_clr = 1'b0;
    reset = 1'b1;
    step(3);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
    n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready); end
    n_checks++; if ({bus.overrun, bus.frame_err, bus.intr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.overrun, bus.frame_err, bus.intr}); end
    reset = 1'b0;
    step(2);
  endtask

  // One frame on tx, compared clock by clock with {stop, data, start}; a stray tx_we mid-frame must be ignored
  task automatic test_tx(input logic [7:0] b);
    logic [9:0] f;
    int bad, busy_n, w;
    f = {1'b1, b, 1'b0};
    bad = 0; busy_n = 0; w = 0;
    @(posedge clock);
    #1;
    bus.tx_data = b; bus.tx_we = 1'b1;
    step(1);
    bus.tx_we = 1'b0; bus.tx_data = ~b;
    for (int k = 0; k < 10 * DIV; k++) begin
      bus.tx_we = (k == 3 * DIV);
      if (tx !== f[k / DIV]) bad++;
      if (bus.tx_busy === 1'b1) busy_n++;
      step(1);
    end
    bus.tx_we = 1'b0;
    while (bus.tx_busy === 1'b1 && w < 4 * DIV) begin busy_n++; w++; step(1); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tx_wave_%h: %0d wrong clocks, want 0", b, bad); end
    n_checks++; if (busy_n != 10 * DIV) begin n_fail++; $display("FAIL tx_busy_len_%h: got %0d want %0d", b, busy_n, 10 * DIV); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle_%h: got %b want 1", b, tx); end
  endtask

  task automatic test_loopback();
    int w;
    loop = 1'b1;
    @(posedge clock);
    #1;
    bus.tx_data = 8'hA3; bus.tx_we = 1'b1;
    step(1);
    bus.tx_we = 1'b0;
    step(9 * DIV);
    n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL lb_early_ready: got %b want 0", bus.rx_ready); end
    w = 0;
    while (bus.tx_busy === 1'b1 && w < 2 * DIV) begin w++; step(1); end
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL lb_busy_fall: still %b after %0d clocks", bus.tx_busy, w); end
    bus.tx_data = 8'h0F; bus.tx_we = 1'b1;
    step(1);
    bus.tx_we = 1'b0;
    n_checks++; if ({bus.tx_busy, tx} !== 2'b10) begin n_fail++; $display("FAIL lb_back_to_back: busy,tx=%b want 10", {bus.tx_busy, tx}); end
    n_checks++; if ({bus.rx_ready, bus.intr, bus.rx_data} !== {2'b11, 8'hA3}) begin n_fail++; $display("FAIL lb_first: ready,intr,data=%b%b %h want 11 a3", bus.rx_ready, bus.intr, bus.rx_data); end
    w = 0;
    while (bus.tx_busy === 1'b1 && w < 11 * DIV) begin w++; step(1); end
    step(DIV);
    n_checks++; if (bus.rx_data !== 8'hA3) begin n_fail++; $display("FAIL lb_head_kept: got %h want a3", bus.rx_data); end
    pop();
    n_checks++; if ({bus.rx_ready, bus.rx_data} !== {1'b1, 8'h0F}) begin n_fail++; $display("FAIL lb_second: ready,data=%b %h want 1 0f", bus.rx_ready, bus.rx_data); end
    pop();
    n_checks++; if ({bus.rx_ready, bus.intr} !== 2'b00) begin n_fail++; $display("FAIL lb_drained: ready,intr=%b want 00", {bus.rx_ready, bus.intr}); end
    loop = 1'b0;
  endtask

  task automatic test_overrun_full();
    logic exp_ovr;
    q.delete();
    exp_ovr = 1'b0;
    for (int v = 0; v < 17; v++) begin
      send_rx(8'(v), 1'b1);
      if (q.size() < 16) q.push_back(8'(v));
      else exp_ovr = 1'b1;
    end
    n_checks++; if ({bus.overrun, bus.rx_ready} !== {exp_ovr, 1'b1}) begin n_fail++; $display("FAIL ovr_set: overrun,ready=%b want %b1", {bus.overrun, bus.rx_ready}, exp_ovr); end
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    // Pop lands on exactly the clock the stop sample pushes into the full FIFO
    fork
      send_rx(8'h11, 1'b1);
      begin
        @(posedge clock);
        repeat (RX_PUSH - 1) @(posedge clock);
        #1;
        n_checks++; if (bus.rx_data !== q[0]) begin n_fail++; $display("FAIL full_head: got %h want %h", bus.rx_data, q[0]); end
        pop();
      end
    join
    void'(q.pop_front());
    q.push_back(8'h11);
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL full_simul_ovr: got %b want 0", bus.overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if ({bus.rx_ready, bus.rx_data} !== {1'b1, q[i]}) begin n_fail++; $display("FAIL fifo_order_%0d: ready,data=%b %h want 1 %h", i, bus.rx_ready, bus.rx_data, q[i]); end
      pop();
    end
    n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_count16: ready=%b want 0 after 16 pops", bus.rx_ready); end
    q.delete();
  endtask

  task automatic test_framing();
    @(posedge clock);
    #1;
    rx_drv = 1'b0;
    step(50);
    rx_drv = 1'b1;
    step(2 * DIV);
    n_checks++; if ({bus.rx_ready, bus.frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch: ready,ferr=%b want 00", {bus.rx_ready, bus.frame_err}); end
    send_rx(8'hC5, 1'b0);
    rx_drv = 1'b1;
    step(DIV);
    n_checks++; if ({bus.rx_ready, bus.frame_err} !== 2'b01) begin n_fail++; $display("FAIL bad_stop: ready,ferr=%b want 01", {bus.rx_ready, bus.frame_err}); end
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", bus.frame_err); end
    fork
      send_rx(8'h33, 1'b0);
      begin
        @(posedge clock);
        repeat (RX_PUSH - 1) @(posedge clock);
        #1;
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
      end
    join
    rx_drv = 1'b1;
    step(DIV);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: ferr=%b want 1", bus.frame_err); end
    send_rx(8'h7E, 1'b1);
    step(DIV);
    n_checks++; if ({bus.rx_ready, bus.rx_data} !== {1'b1, 8'h7E}) begin n_fail++; $display("FAIL after_ferr: ready,data=%b %h want 1 7e", bus.rx_ready, bus.rx_data); end
    pop();
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      q.push_back(b);
      if ($urandom_range(0, 1) == 1) begin
        n_checks++; if (bus.rx_data !== q[0]) begin n_fail++; $display("FAIL rand_mid_%0d: got %h want %h", i, bus.rx_data, q[0]); end
        void'(q.pop_front());
        pop();
      end
    end
    while (q.size() > 0) begin
      n_checks++; if ({bus.rx_ready, bus.rx_data} !== {1'b1, q[0]}) begin n_fail++; $display("FAIL rand_drain: ready,data=%b %h want 1 %h", bus.rx_ready, bus.rx_data, q[0]); end
      void'(q.pop_front());
      pop();
    end
    n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rand_empty: ready=%b want 0", bus.rx_ready); end
    test_tx(8'($urandom));
  endtask

  task automatic test_reset_mid();
    logic [9:0] f;
    f = {1'b1, 8'h96, 1'b0};
    send_rx(8'h5A, 1'b1);
    @(posedge clock);
    #1;
    bus.tx_data = 8'h3C; bus.tx_we = 1'b1; rx_drv = 1'b0;
    step(1);
    bus.tx_we = 1'b0;
    step(DIV - 1);
    for (int i = 1; i <= 4; i++) begin
      rx_drv = f[i];
      step(DIV);
    end
    rx_drv = f[5];
    step(DIV / 2);
    #5 reset = 1'b1;
    #1;
    n_checks++; if ({tx, bus.tx_busy} !== 2'b10) begin n_fail++; $display("FAIL midrst_tx: tx,busy=%b want 10", {tx, bus.tx_busy}); end
    n_checks++; if ({bus.rx_ready, bus.intr, bus.rx_data} !== 10'h000) begin n_fail++; $display("FAIL midrst_rx: ready,intr,data=%b%b %h want 00 00", bus.rx_ready, bus.intr, bus.rx_data); end
    rx_drv = 1'b1;
    step(3);
    reset = 1'b0;
    step(DIV);
    send_rx(8'h96, 1'b1);
    step(DIV);
    n_checks++; if ({bus.rx_ready, bus.rx_data} !== {1'b1, 8'h96}) begin n_fail++; $display("FAIL midrst_rx_after: ready,data=%b %h want 1 96", bus.rx_ready, bus.rx_data); end
    pop();
    test_tx(8'h3C);
  endtask

  initial begin
    test_reset();
    test_tx(8'h55);
    test_loopback();
    test_overrun_full();
    test_framing();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
